// File: rtl/ppu_pkg.sv
// Shared types and defaults for the post-processing write-back stage:
// FSM state encoding, default widths and the signed saturation bounds.
package ppu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ppu_state_e;

    localparam int PPU_LANES   = 16;
    localparam int PPU_ACC_W   = 24;
    localparam int PPU_OUT_W   = 4;
    localparam int PPU_ADDR_W  = 13;
    localparam int PPU_SHIFT_W = 5;
    localparam int SAT_CNT_W   = 16;

    function automatic int sat_hi(input int out_w);
        return (32'sd1 <<< (out_w - 32'sd1)) - 32'sd1;
    endfunction

    function automatic int sat_lo(input int out_w);
        return -(32'sd1 <<< (out_w - 32'sd1));
    endfunction

endpackage

// File: rtl/ppu_writeback_if.sv
// Config, accumulator-stream, RAM-write and status signals of ppu_writeback.
// slave is the write-back stage's view, master the controller/RAM side.
interface ppu_writeback_if import ppu_pkg::*; #(
    parameter int LANES   = PPU_LANES,
    parameter int ACC_W   = PPU_ACC_W,
    parameter int OUT_W   = PPU_OUT_W,
    parameter int ADDR_W  = PPU_ADDR_W,
    parameter int SHIFT_W = PPU_SHIFT_W
) ();

    logic                     i_start;
    logic [SHIFT_W-1:0]       i_cfg_shift;
    logic [ADDR_W-1:0]        i_cfg_base;
    logic [ADDR_W-1:0]        i_cfg_len;
    logic                     i_acc_valid;
    logic                     o_acc_ready;
    logic [LANES*ACC_W-1:0]   i_acc_data;
    logic                     i_ram_stall;
    logic                     o_ram_we;
    logic [ADDR_W-1:0]        o_ram_addr;
    logic [LANES*OUT_W-1:0]   o_ram_data;
    logic                     o_busy;
    logic                     o_done;
    logic [SAT_CNT_W-1:0]     o_sat_cnt;

    modport slave (
        input  i_start, i_cfg_shift, i_cfg_base, i_cfg_len,
        input  i_acc_valid, i_acc_data, i_ram_stall,
        output o_acc_ready, o_ram_we, o_ram_addr, o_ram_data,
        output o_busy, o_done, o_sat_cnt
    );

    modport master (
        output i_start, i_cfg_shift, i_cfg_base, i_cfg_len,
        output i_acc_valid, i_acc_data, i_ram_stall,
        input  o_acc_ready, o_ram_we, o_ram_addr, o_ram_data,
        input  o_busy, o_done, o_sat_cnt
    );

endinterface

// File: rtl/ppu_requant_lane.sv
// Single-lane requantiser: rounding arithmetic right shift followed by
// saturation to signed OUT_W, with a flag when the value was clipped.
module ppu_requant_lane import ppu_pkg::*; #(
    parameter int ACC_W   = PPU_ACC_W,
    parameter int OUT_W   = PPU_OUT_W,
    parameter int SHIFT_W = PPU_SHIFT_W
) (
    input  logic [ACC_W-1:0]   i_x,
    input  logic [SHIFT_W-1:0] i_shift,
    output logic [OUT_W-1:0]   o_y,
    output logic               o_sat
);

    localparam logic signed [ACC_W:0]   SAT_HI    = (ACC_W+1)'(sat_hi(OUT_W));
    localparam logic signed [ACC_W:0]   SAT_LO    = (ACC_W+1)'(sat_lo(OUT_W));
    localparam logic signed [ACC_W:0]   RND_ONE   = {{ACC_W{1'b0}}, 1'b1};
    localparam logic [SHIFT_W-1:0]      SHIFT_ONE = {{(SHIFT_W-1){1'b0}}, 1'b1};

    logic signed [ACC_W:0] x_ext;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] y;

    // Round-half-up shift in ACC_W+1 bits so the rounding add cannot overflow, then clip
    always_comb begin
        x_ext = {i_x[ACC_W-1], i_x};
        if (i_shift == '0) begin
            rnd = '0;
        end else begin
            rnd = RND_ONE <<< (i_shift - SHIFT_ONE);
        end
        y = (x_ext + rnd) >>> i_shift;
        if (y > SAT_HI) begin
            o_y   = SAT_HI[OUT_W-1:0];
            o_sat = 1'b1;
        end else if (y < SAT_LO) begin
            o_y   = SAT_LO[OUT_W-1:0];
            o_sat = 1'b1;
        end else begin
            o_y   = y[OUT_W-1:0];
            o_sat = 1'b0;
        end
    end

endmodule

// File: rtl/ppu_writeback.sv
// Write-back stage: requantises accumulator vectors, packs them into RAM words
// and writes a run of len words from base, honouring RAM stalls.
module ppu_writeback import ppu_pkg::*; #(
    parameter int LANES   = PPU_LANES,
    parameter int ACC_W   = PPU_ACC_W,
    parameter int OUT_W   = PPU_OUT_W,
    parameter int ADDR_W  = PPU_ADDR_W,
    parameter int SHIFT_W = PPU_SHIFT_W
) (
    input  logic           i_clk,
    input  logic           i_rst,
    ppu_writeback_if.slave bus
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    ppu_state_e state_q, state_d;

    logic [SHIFT_W-1:0]     shift_q,   shift_d;
    logic [ADDR_W-1:0]      base_q,    base_d;
    logic [ADDR_W-1:0]      len_q,     len_d;
    logic [ADDR_W-1:0]      in_cnt_q,  in_cnt_d;
    logic [ADDR_W-1:0]      out_cnt_q, out_cnt_d;
    logic [SAT_CNT_W-1:0]   sat_cnt_q, sat_cnt_d;
    logic                   we_q,      we_d;
    logic [ADDR_W-1:0]      addr_q,    addr_d;
    logic [LANES*OUT_W-1:0] data_q,    data_d;

    logic                   acc_ready;
    logic                   busy;
    logic                   done;
    logic                   start_ok;
    logic                   hs;
    logic                   commit;
    logic                   last_commit;
    logic [LANES*OUT_W-1:0] packed_w;
    logic [LANES-1:0]       lane_sat;
    logic [SAT_CNT_W:0]     sat_inc;
    logic [SAT_CNT_W:0]     sat_sum;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        ppu_requant_lane #(
            .ACC_W   (ACC_W),
            .OUT_W   (OUT_W),
            .SHIFT_W (SHIFT_W)
        ) u_lane (
            .i_x     (bus.i_acc_data[k*ACC_W +: ACC_W]),
            .i_shift (shift_q),
            .o_y     (packed_w[k*OUT_W +: OUT_W]),
            .o_sat   (lane_sat[k])
        );
    end

    assign start_ok    = (state_q == IDLE) && bus.i_start;
    assign hs          = bus.i_acc_valid && acc_ready;
    assign commit      = (state_q == RUN) && we_q && !bus.i_ram_stall;
    assign last_commit = ((out_cnt_q + ADDR_ONE) == len_q);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d = (bus.i_cfg_len == '0) ? DONE : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (commit && last_commit) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; ready deliberately looks at the live stall so a stalled word blocks intake
    always_comb begin
        acc_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            RUN: begin
                busy      = 1'b1;
                acc_ready = (in_cnt_q < len_q) && (!we_q || !bus.i_ram_stall);
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                acc_ready = 1'b0;
            end
        endcase
    end

    // Number of clipped lanes on the word currently presented
    always_comb begin
        sat_inc = '0;
        for (int k = 0; k < LANES; k++) begin
            sat_inc = sat_inc + {{SAT_CNT_W{1'b0}}, lane_sat[k]};
        end
        sat_sum = {1'b0, sat_cnt_q} + sat_inc;
    end

    // Datapath next values: job config latch, counters, output register
    always_comb begin
        shift_d   = shift_q;
        base_d    = base_q;
        len_d     = len_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        sat_cnt_d = sat_cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        data_d    = data_q;
        if (start_ok) begin
            shift_d   = bus.i_cfg_shift;
            base_d    = bus.i_cfg_base;
            len_d     = bus.i_cfg_len;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            sat_cnt_d = '0;
            we_d      = 1'b0;
        end else begin
            if (commit) begin
                out_cnt_d = out_cnt_q + ADDR_ONE;
                we_d      = 1'b0;
            end else begin
                out_cnt_d = out_cnt_q;
            end
            // A new word in the same cycle as a commit reloads the register and keeps we high
            if (hs) begin
                we_d      = 1'b1;
                addr_d    = base_q + in_cnt_q;
                data_d    = packed_w;
                in_cnt_d  = in_cnt_q + ADDR_ONE;
                sat_cnt_d = sat_sum[SAT_CNT_W] ? {SAT_CNT_W{1'b1}} : sat_sum[SAT_CNT_W-1:0];
            end else begin
                in_cnt_d  = in_cnt_q;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shift_q   <= '0;
            base_q    <= '0;
            len_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            sat_cnt_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            shift_q   <= shift_d;
            base_q    <= base_d;
            len_q     <= len_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            sat_cnt_q <= sat_cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign bus.o_acc_ready = acc_ready;
    assign bus.o_ram_we    = we_q;
    assign bus.o_ram_addr  = addr_q;
    assign bus.o_ram_data  = data_q;
    assign bus.o_busy      = busy;
    assign bus.o_done      = done;
    assign bus.o_sat_cnt   = sat_cnt_q;

endmodule
